// File: rtl/drfa_pkg.sv
// Shared definitions for the DRFA 8-bit CPU front end.
//   CODE_ADDR_W   : code memory address width (512 words)
//   INSTR_W       : instruction word width
//   RESET_PC      : first fetch address after reset
//   fetch_entry_t : one buffered instruction {instr, pc}, also seen by control_unit
//   fetch_state_e : fetch front-end state (the redirect is handled inside RUN)
package drfa_pkg;

  localparam int CODE_ADDR_W = 9;
  localparam int INSTR_W     = 16;
  localparam int RESET_PC    = 0;

  typedef struct packed {
    logic [INSTR_W-1:0]     instr;
    logic [CODE_ADDR_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetched {instr, pc} pairs.
//   push/push_instr/push_pc : enqueue one entry at the clock edge
//   pop                     : drop the head at the clock edge (ignored when empty)
//   flush                   : empty the queue; wins over push
//   count                   : number of valid entries, 0..2
//   head_*                  : registered head entry and its valid flag
// Entry 0 is always the head, so the head outputs come straight from flops.
module fetch_queue #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic               head_valid
);

  logic [INSTR_W-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [ADDR_W-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    // A push into a full queue without a pop has nowhere to go; the issue
    // logic upstream never lets that happen.
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            instr0_d = push_instr;
            pc0_d    = push_pc;
          end else begin
            instr1_d = push_instr;
            pc1_d    = push_pc;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          instr0_d = instr1_q;
          pc0_d    = pc1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            instr0_d = push_instr;
            pc0_d    = push_pc;
          end else begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
            instr1_d = push_instr;
            pc1_d    = push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr0_q <= '0;
      instr1_q <= '0;
      pc0_q    <= '0;
      pc1_q    <= '0;
      count_q  <= 2'd0;
    end else begin
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_instr = instr0_q;
  assign head_pc    = pc0_q;
  assign head_valid = (count_q != 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, strobes the synchronous
// code memory and buffers returned words in a 2-entry queue for control_unit.
//   out_code_rd_en/out_code_addr : code memory read strobe and address
//   in_code_data                 : read data, one cycle after the strobe
//   out_ir/out_ir_pc/out_ir_valid: registered queue head
//   in_ir_ready                  : head consumed when out_ir_valid=1
//   in_pc_load/in_pc_value       : redirect pulse and target
// Handshake: an instruction moves to control_unit in every cycle where
// out_ir_valid && in_ir_ready at the rising edge; out_ir_valid never
// depends combinationally on in_ir_ready.
module fetch_unit #(
  parameter int CODE_ADDR_W = drfa_pkg::CODE_ADDR_W,
  parameter int INSTR_W     = drfa_pkg::INSTR_W,
  parameter int RESET_PC    = drfa_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   out_code_rd_en,
  output logic [CODE_ADDR_W-1:0] out_code_addr,
  input  logic [INSTR_W-1:0]     in_code_data,
  output logic [INSTR_W-1:0]     out_ir,
  output logic [CODE_ADDR_W-1:0] out_ir_pc,
  output logic                   out_ir_valid,
  input  logic                   in_ir_ready,
  input  logic                   in_pc_load,
  input  logic [CODE_ADDR_W-1:0] in_pc_value
);

  localparam logic [CODE_ADDR_W-1:0] RESET_FPC = CODE_ADDR_W'(RESET_PC);

  drfa_pkg::fetch_state_e state_q, state_d;

  logic [CODE_ADDR_W-1:0] fpc_q, fpc_d;
  logic [CODE_ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic                   inflight_q, inflight_d;
  logic [1:0]             count;
  logic [2:0]             occupancy;
  logic                   pop, push, issue;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= drfa_pkg::ST_RESET;
    else        state_q <= state_d;
  end

  // Next state: RUN from the first edge after reset release onwards.
  always_comb begin
    state_d = drfa_pkg::ST_RUN;
  end

  // Issue / push / redirect decisions.
  always_comb begin
    pop = out_ir_valid && in_ir_ready;
    // Slots already claimed once this cycle's pop retires; pop implies
    // count >= 1, so this never goes below zero.
    occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue = rst_n && !in_pc_load && (occupancy < 3'd2);
    // A response landing in a redirect cycle belongs to the old stream.
    push = inflight_q && !in_pc_load && (state_q == drfa_pkg::ST_RUN);
    out_code_rd_en = issue;
    out_code_addr  = fpc_q;
  end

  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (in_pc_load) begin
      fpc_d = in_pc_value;
    end else if (issue) begin
      fpc_d         = fpc_q + 1'b1;  // wraps 511 -> 0
      inflight_pc_d = fpc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q         <= RESET_FPC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (CODE_ADDR_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_instr (in_code_data),
    .push_pc    (inflight_pc_q),
    .pop        (pop),
    .flush      (in_pc_load),
    .count      (count),
    .head_instr (out_ir),
    .head_pc    (out_ir_pc),
    .head_valid (out_ir_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        out_code_rd_en;
  logic [8:0]  out_code_addr;
  logic [15:0] in_code_data;
  logic [15:0] out_ir;
  logic [8:0]  out_ir_pc;
  logic        out_ir_valid;
  logic        in_ir_ready;
  logic        in_pc_load;
  logic [8:0]  in_pc_value;

  int total = 0;
  int bad   = 0;

  logic [24:0] exp_q[$];  // {instr, pc} expected at each consumption

  typedef struct {
    logic       ready;
    logic       load;
    logic [8:0] value;
    logic       rd_en;
    logic [8:0] addr;
    logic       valid;
    logic [8:0] ir_pc;
  } vec_t;

  vec_t vecs[13];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .out_code_rd_en (out_code_rd_en),
    .out_code_addr  (out_code_addr),
    .in_code_data   (in_code_data),
    .out_ir         (out_ir),
    .out_ir_pc      (out_ir_pc),
    .out_ir_valid   (out_ir_valid),
    .in_ir_ready    (in_ir_ready),
    .in_pc_load     (in_pc_load),
    .in_pc_value    (in_pc_value)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [8:0] a);
    return 16'hA000 + {7'b0, a};
  endfunction

  // synchronous code memory: word k = A000+k, one cycle read latency
  always @(posedge clk) begin
    if (out_code_rd_en) in_code_data <= mem_word(out_code_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Holds reset for a few cycles, checks reset values, releases just after
  // a rising edge; returns inside cycle 0.
  task automatic do_reset(input logic ready);
    rst_n       = 1'b0;
    in_pc_load  = 1'b0;
    in_pc_value = '0;
    in_ir_ready = ready;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", {31'b0, out_code_rd_en}, 32'd0);
    check("rst_addr", {23'b0, out_code_addr}, 32'd0);
    check("rst_ir", {16'b0, out_ir}, 32'd0);
    check("rst_ir_pc", {23'b0, out_ir_pc}, 32'd0);
    check("rst_valid", {31'b0, out_ir_valid}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Compares every consumption against exp_q until it drains or the budget ends.
  task automatic sb_run(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      if (out_ir_valid && in_ir_ready) begin
        logic [24:0] e;
        e = exp_q.pop_front();
        check("sb_ir", {16'b0, out_ir}, {16'b0, e[24:9]});
        check("sb_ir_pc", {23'b0, out_ir_pc}, {23'b0, e[8:0]});
      end
      n++;
    end
    check("sb_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [8:0] pc);
    exp_q.push_back({mem_word(pc), pc});
  endtask

  initial begin
    int strobes;
    rst_n        = 1'b0;
    in_ir_ready  = 1'b0;
    in_pc_load   = 1'b0;
    in_pc_value  = '0;
    in_code_data = '0;

    // cycle-accurate stream, redirect to 1F0 with a pop in the same cycle,
    // then back-pressure and recovery
    //            ready load value   rd_en addr    valid ir_pc
    vecs[0]  = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h000, 1'b0, 9'h000};
    vecs[1]  = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h001, 1'b0, 9'h000};
    vecs[2]  = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h002, 1'b1, 9'h000};
    vecs[3]  = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h003, 1'b1, 9'h001};
    vecs[4]  = '{1'b1, 1'b1, 9'h1F0, 1'b0, 9'h004, 1'b1, 9'h002};
    vecs[5]  = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h1F0, 1'b0, 9'h000};
    vecs[6]  = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h1F1, 1'b0, 9'h000};
    vecs[7]  = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h1F2, 1'b1, 9'h1F0};
    vecs[8]  = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h1F3, 1'b1, 9'h1F1};
    vecs[9]  = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h1F3, 1'b1, 9'h1F1};
    vecs[10] = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h1F3, 1'b1, 9'h1F1};
    vecs[11] = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h1F4, 1'b1, 9'h1F2};
    vecs[12] = '{1'b1, 1'b0, 9'h000, 1'b1, 9'h1F5, 1'b1, 9'h1F3};

    do_reset(1'b1);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) next_cycle();
      in_ir_ready = vecs[i].ready;
      in_pc_load  = vecs[i].load;
      in_pc_value = vecs[i].value;
      @(negedge clk);
      check($sformatf("v%0d_rd_en", i), {31'b0, out_code_rd_en}, {31'b0, vecs[i].rd_en});
      if (vecs[i].rd_en)
        check($sformatf("v%0d_addr", i), {23'b0, out_code_addr}, {23'b0, vecs[i].addr});
      check($sformatf("v%0d_valid", i), {31'b0, out_ir_valid}, {31'b0, vecs[i].valid});
      if (vecs[i].valid) begin
        check($sformatf("v%0d_ir_pc", i), {23'b0, out_ir_pc}, {23'b0, vecs[i].ir_pc});
        check($sformatf("v%0d_ir", i), {16'b0, out_ir}, {16'b0, mem_word(vecs[i].ir_pc)});
      end
    end

    // redirect to 511 while streaming: pcs wrap 511, 0, 1, 2
    next_cycle();
    in_pc_load  = 1'b1;
    in_pc_value = 9'h1FF;
    push_exp(9'h1FF);
    push_exp(9'h000);
    push_exp(9'h001);
    push_exp(9'h002);
    next_cycle();
    in_pc_load = 1'b0;
    sb_run(20);

    // back-pressure from reset: exactly two strobes, head held stable
    do_reset(1'b0);
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      if (out_code_rd_en) strobes++;
      if (c >= 2) check($sformatf("hold_ir_c%0d", c), {16'b0, out_ir}, 32'hA000);
    end
    check("hold_strobes", strobes, 32'd2);
    next_cycle();
    in_ir_ready = 1'b1;
    #1;
    check("resume_rd_en", {31'b0, out_code_rd_en}, 32'd1);
    check("resume_addr", {23'b0, out_code_addr}, 32'd2);
    for (int k = 0; k < 4; k++) push_exp(k[8:0]);
    sb_run(20);

    // asynchronous reset mid-cycle with a word buffered and a read in flight
    do_reset(1'b0);
    next_cycle();
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rd_en", {31'b0, out_code_rd_en}, 32'd0);
    check("rst_mid_addr", {23'b0, out_code_addr}, 32'd0);
    check("rst_mid_ir", {16'b0, out_ir}, 32'd0);
    check("rst_mid_ir_pc", {23'b0, out_ir_pc}, 32'd0);
    check("rst_mid_valid", {31'b0, out_ir_valid}, 32'd0);
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) push_exp(k[8:0]);
    sb_run(20);

    // random redirect targets: target word is presented three cycles later
    for (int r = 0; r < 4; r++) begin
      logic [8:0] tgt;
      tgt = 9'($urandom_range(0, 511));
      next_cycle();
      in_ir_ready = 1'b1;
      in_pc_load  = 1'b1;
      in_pc_value = tgt;
      next_cycle();
      in_pc_load = 1'b0;
      @(negedge clk);
      check($sformatf("rnd%0d_addr", r), {23'b0, out_code_addr}, {23'b0, tgt});
      check($sformatf("rnd%0d_n1_valid", r), {31'b0, out_ir_valid}, 32'd0);
      next_cycle();
      @(negedge clk);
      check($sformatf("rnd%0d_n2_valid", r), {31'b0, out_ir_valid}, 32'd0);
      push_exp(tgt);
      push_exp(tgt + 9'd1);
      sb_run(10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the DRFA 8-bit CPU. It owns the fetch program counter, issues reads to the synchronous code memory, and buffers returned 16-bit instruction words in a 2-entry queue. It presents them to `control_unit` through a valid/ready handshake, so `control_unit` only consumes instructions and issues redirects (jumps). It replaces the hand-sequenced PC_inc / IR_load fetch micro-steps.

## Interface
Parameters:
- `CODE_ADDR_W`, default 9: code memory address width (512 words).
- `INSTR_W`, default 16: instruction word width.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `out_code_rd_en`  out  1  code memory read strobe.
- `out_code_addr`  out  CODE_ADDR_W  code memory read address, valid when `out_code_rd_en`=1.
- `in_code_data`  in  INSTR_W  read data, valid in the cycle after the strobe.
- `out_ir`  out  INSTR_W  instruction at queue head.
- `out_ir_pc`  out  CODE_ADDR_W  address `out_ir` was fetched from.
- `out_ir_valid`  out  1  queue head is valid.
- `in_ir_ready`  in  1  `control_unit` consumes the head this cycle when `out_ir_valid`=1.
- `in_pc_load`  in  1  redirect request; single-cycle pulse.
- `in_pc_value`  in  CODE_ADDR_W  redirect target.

## Operation
- Fetch PC `fpc`: address of the next read. It increments by 1 on every issued read and wraps from 511 to 0 with no flag.
- Queue: 2 entries of {instr, pc}. `count` ranges 0..2. `inflight` is 1 when a read was issued last cycle.
- Pop: `out_ir_valid && in_ir_ready`.
- Issue rule: strobe when `!in_pc_load && (count + inflight - pop) < 2`. Counting the pop gives sustained throughput of 1 instruction per cycle.
- Response: when `inflight`=1, `{in_code_data, pc}` is pushed at the clock edge. A push and a pop in the same cycle are both honoured.
- Redirect: in the cycle `in_pc_load`=1:
  - no read is issued;
  - any response arriving that cycle is discarded;
  - the queue is cleared at the edge;
  - `fpc` <= `in_pc_value`.
- A pop in the redirect cycle is still a valid consumption of the presented head.
- `in_pc_load` held for several cycles: each cycle repeats the redirect, and the last value wins.
- States:
  - RESET: `rst_n`=0.
  - RUN: normal issue/push/pop.
  - REDIRECT: the single `in_pc_load` cycle, handled combinationally within RUN and not a separate registered state.
  - RUN is entered on the first edge after `rst_n` rises.

## Timing
- Reset values:
  - `out_code_rd_en`=0, `out_code_addr`=RESET_PC, `out_ir`=0, `out_ir_pc`=0, `out_ir_valid`=0.
  - `count`=0, `inflight`=0, `fpc`=RESET_PC.
- Reset is asynchronous and takes effect mid-transfer. Queue contents and in-flight reads are lost. No strobe is driven while `rst_n`=0.
- First cycle after deassertion: strobe at RESET_PC. Data arrives in the next cycle. `out_ir_valid`=1 in the cycle after that, giving 2-cycle fetch latency.
- Redirect in cycle N:
  - no strobe in N;
  - strobe at the target in N+1;
  - `out_ir_valid`=1 with the target instruction in N+3;
  - `out_ir_valid`=0 in N+1 and N+2.
- `out_ir`, `out_ir_pc` and `out_ir_valid` are registered (driven from queue storage). There is no combinational path from `in_code_data` or `in_ir_ready` to these outputs.
- `out_code_rd_en` depends combinationally on `in_ir_ready` and `in_pc_load`. `control_unit` drives both from registered state.
- Queue full (`count`=2, no pop): no strobe, head held stable until popped.

## Structure
- Shared package `drfa_pkg`: `CODE_ADDR_W`, `INSTR_W`, `RESET_PC`, and a fetch-entry typedef {instr, pc}, also used by `control_unit`.
- One sub-module, `fetch_queue`: 2-entry synchronous FIFO with push, pop and flush, exposing `count` and the head. Flush has priority over push.
- `fetch_unit` holds `fpc`, `inflight` and the issue logic.

## Test plan
- Reset release with memory word k = 16'hA000+k, ready held 1 → strobes at 0,1,2,…; `out_ir_valid` from cycle 2; `out_ir`=A000,A001,… on consecutive cycles with `out_ir_pc`=0,1,….
- Ready held 0 → exactly two strobes (addr 0,1), then `out_code_rd_en`=0. `out_ir`=A000 is stable. When ready rises, A000 then A001 are delivered back-to-back and fetch resumes at 2.
- `in_pc_load`=1 with `in_pc_value`=9'h1F0 in cycle N while streaming → no strobe in N; strobe at 1F0 in N+1; `out_ir`=A1F0 valid in N+3; no stale word appears.
- Redirect to 511 with ready=1 → `out_ir_pc` sequence 511, 0, 1; addresses wrap with no glitch.
- `rst_n` asserted while `count`=2 and a read is in flight → outputs reach reset values immediately. After release, the first `out_ir` is the RESET_PC word.
- `in_pc_load` and pop in the same cycle → the presented head counts as consumed once; the queue is empty next cycle; the target word follows at N+3.
